// File: rtl/skolem_sweep_checker_if.sv
// Bus between the Skolem sweep checker (master) and the block under check plus its observer (slave).
interface skolem_sweep_checker_if #(
    parameter int unsigned W = 4
);
    logic         start;
    logic [W-1:0] s_out;
    logic [W-1:0] t_out;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic [2*W:0] pass_count;
    logic [2*W:0] fail_count;
    logic [2*W:0] skip_count;
    logic [W-1:0] first_fail_s;
    logic [W-1:0] first_fail_t;
    logic         fail_seen;

    modport master (
        input  start, x_in,
        output s_out, t_out, busy, done, pass_count, fail_count, skip_count,
               first_fail_s, first_fail_t, fail_seen
    );

    modport slave (
        output start, x_in,
        input  s_out, t_out, busy, done, pass_count, fail_count, skip_count,
               first_fail_s, first_fail_t, fail_seen
    );
endinterface

// File: rtl/skolem_sweep_checker.sv
// Exhaustive (s,t) sweep and bit-serial urem check of the Skolem witness for "x urem s != t".
// Define SKOLEM_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first failing pair.
module skolem_sweep_checker #(
    parameter int unsigned W      = 4,
    parameter int unsigned SETTLE = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    skolem_sweep_checker_if.master bus
);

`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);
    localparam logic [IW-1:0] IdxTop     = IW'(W - 1);
    localparam logic [W-1:0]  Max        = '1;

    typedef enum logic [2:0] {StIdle, StDrive, StDiv, StCheck, StDone} state_e;

    state_e        state;
    logic [W-1:0]  xr;
    logic [W:0]    rem;
    logic [IW-1:0] idx;
    logic [SW-1:0] settle_cnt;

    logic [W:0]    rem_shift;
    logic          rem_ge;
    logic          ic;
    logic          hit;

    always_comb begin
        rem_shift = {rem[W-1:0], xr[idx]};
        // A zero divisor never subtracts, so rem ends up equal to xr (x urem 0 = x).
        rem_ge    = (bus.s_out != '0) && (rem_shift >= {1'b0, bus.s_out});
        ic        = (bus.s_out != W'(1)) || (bus.t_out != '0);
        // rem[W] is always 0 after a restoring step, so the full compare is the W-bit compare.
        hit       = ic && (rem == {1'b0, bus.t_out});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            xr               <= '0;
            rem              <= '0;
            idx              <= '0;
            settle_cnt       <= '0;
            bus.s_out        <= '0;
            bus.t_out        <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.pass_count   <= '0;
            bus.fail_count   <= '0;
            bus.skip_count   <= '0;
            bus.first_fail_s <= '0;
            bus.first_fail_t <= '0;
            bus.fail_seen    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        bus.s_out        <= '0;
                        bus.t_out        <= '0;
                        bus.pass_count   <= '0;
                        bus.fail_count   <= '0;
                        bus.skip_count   <= '0;
                        bus.first_fail_s <= '0;
                        bus.first_fail_t <= '0;
                        bus.fail_seen    <= 1'b0;
                        bus.busy         <= 1'b1;
                        settle_cnt       <= '0;
                        state            <= StDrive;
                    end
                end
                StDrive: begin
                    if (settle_cnt == SettleLast) begin
                        xr    <= bus.x_in;
                        rem   <= '0;
                        idx   <= IdxTop;
                        state <= StDiv;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StDiv: begin
                    rem <= rem_ge ? (rem_shift - {1'b0, bus.s_out}) : rem_shift;
                    if (idx == '0) begin
                        state <= StCheck;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                StCheck: begin
                    if (!ic) begin
                        bus.skip_count <= bus.skip_count + 1'b1;
                    end else if (hit) begin
                        bus.fail_count <= bus.fail_count + 1'b1;
                        if (!bus.fail_seen) begin
                            bus.first_fail_s <= bus.s_out;
                            bus.first_fail_t <= bus.t_out;
                        end
                        bus.fail_seen <= 1'b1;
                    end else begin
                        bus.pass_count <= bus.pass_count + 1'b1;
                    end
                    settle_cnt <= '0;
                    if ((StopOnFail && hit) || (bus.s_out == Max && bus.t_out == Max)) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= StDone;
                    end else begin
                        bus.t_out <= bus.t_out + 1'b1;
                        if (bus.t_out == Max) begin
                            bus.s_out <= bus.s_out + 1'b1;
                        end
                        state <= StDrive;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Scoreboard bench for skolem_sweep_checker: behavioural Skolem models drive x_in, a direct
// x % s model predicts the sweep totals and cycle counts.
module tb_skolem_sweep_checker;
    localparam int unsigned W = 4;

`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // Fields: pass, fail, skip, fail_seen, ffs, fft, cycles, done pulses, busy early, busy at done
    typedef logic [9:0][31:0] res_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    mode1 = 0;
    int    mode3 = 0;
    int    checks = 0;
    int    passes = 0;
    res_t  sb[$];
    string fname[10] = '{"pass_count", "fail_count", "skip_count", "fail_seen", "first_fail_s",
                         "first_fail_t", "cycles", "done_pulses", "busy_early", "busy_at_done"};

    always #5 clk = ~clk;

    skolem_sweep_checker_if #(.W(W)) bus1 ();
    skolem_sweep_checker_if #(.W(W)) bus3 ();

    skolem_sweep_checker #(.W(W), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    skolem_sweep_checker #(.W(W), .SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [3:0] skolem(int mode, logic [3:0] s, logic [3:0] t);
        logic [3:0] x;
        x = (s == 4'd0) ? ~t : ((t == 4'd0) ? 4'd1 : 4'd0);
        if (mode == 1) x = t;
        else if (mode == 2 && s == 4'd5 && t == 4'd3) x = 4'd3;
        return x;
    endfunction

    assign bus1.x_in = skolem(mode1, bus1.s_out, bus1.t_out);

    // The SETTLE=3 block only shows a valid witness once s/t have been stable for two cycles.
    logic [7:0] last3 = '0;
    int         stable_cnt = 0;
    always_ff @(posedge clk) begin
        last3 <= {bus3.s_out, bus3.t_out};
        if ({bus3.s_out, bus3.t_out} != last3) stable_cnt <= 0;
        else if (stable_cnt < 4) stable_cnt <= stable_cnt + 1;
    end
    assign bus3.x_in = (({bus3.s_out, bus3.t_out} == last3) && stable_cnt >= 1)
                       ? skolem(mode3, bus3.s_out, bus3.t_out) : bus3.t_out;

    function automatic res_t expect_sweep(int mode, int settle);
        res_t e;
        int   x;
        int   r;
        e = '0;
        for (int p = 0; p < 256; p++) begin
            int s;
            int t;
            s = p / 16;
            t = p % 16;
            x = int'(skolem(mode, 4'(s), 4'(t)));
            r = (s == 0) ? x : x % s;
            e[6] = (p + 1) * (settle + W + 1);
            if (s == 1 && t == 0) begin
                e[2] = e[2] + 1;
            end else if (r == t) begin
                if (e[3] == 0) begin
                    e[4] = s;
                    e[5] = t;
                end
                e[1] = e[1] + 1;
                e[3] = 1;
                if (STOP) break;
            end else begin
                e[0] = e[0] + 1;
            end
        end
        e[7] = 1;
        e[8] = 1;
        e[9] = 0;
        return e;
    endfunction

    function automatic logic [63:0] all_outs(int sel);
        if (sel == 1)
            return 64'({bus3.busy, bus3.done, bus3.pass_count, bus3.fail_count, bus3.skip_count,
                        bus3.first_fail_s, bus3.first_fail_t, bus3.fail_seen, bus3.s_out,
                        bus3.t_out});
        return 64'({bus1.busy, bus1.done, bus1.pass_count, bus1.fail_count, bus1.skip_count,
                    bus1.first_fail_s, bus1.first_fail_t, bus1.fail_seen, bus1.s_out,
                    bus1.t_out});
    endfunction

    task automatic drive_start(input int sel, input bit v);
        if (sel == 1) bus3.start = v;
        else bus1.start = v;
    endtask

    task automatic run_sweep(input int sel, input int pulse_at, output res_t obs);
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        obs = '0;
        @(negedge clk);
        drive_start(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_start(sel, 1'b0);
        while (!got && cnt < 4000) begin
            @(posedge clk);
            cnt++;
            #1;
            drive_start(sel, cnt == pulse_at);
            if (cnt == 1) obs[8] = 32'((sel == 1) ? bus3.busy : bus1.busy);
            got = (sel == 1) ? bus3.done : bus1.done;
        end
        if (sel == 1) begin
            obs[0] = 32'(bus3.pass_count);   obs[1] = 32'(bus3.fail_count);
            obs[2] = 32'(bus3.skip_count);   obs[3] = 32'(bus3.fail_seen);
            obs[4] = 32'(bus3.first_fail_s); obs[5] = 32'(bus3.first_fail_t);
            obs[9] = 32'(bus3.busy);
        end else begin
            obs[0] = 32'(bus1.pass_count);   obs[1] = 32'(bus1.fail_count);
            obs[2] = 32'(bus1.skip_count);   obs[3] = 32'(bus1.fail_seen);
            obs[4] = 32'(bus1.first_fail_s); obs[5] = 32'(bus1.first_fail_t);
            obs[9] = 32'(bus1.busy);
        end
        obs[6] = got ? cnt : -1;
        obs[7] = 32'(got);
        @(posedge clk);
        #1;
        if ((sel == 1) ? bus3.done : bus1.done) obs[7] = obs[7] + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int sel = 0; sel < 2; sel++) begin
            checks++;
            if (all_outs(sel) !== 64'd0)
                $display("FAIL reset_outputs dut%0d: got %h, expected 0", sel, all_outs(sel));
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        res_t obs, exp;
        mode1 = 0;
        sb.push_back(expect_sweep(0, 1));
        run_sweep(0, 0, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL correct.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_broken();
        res_t obs, exp;
        mode1 = 1;
        sb.push_back(expect_sweep(1, 1));
        run_sweep(0, 0, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL broken.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_single_fault();
        res_t obs, exp;
        mode1 = 2;
        sb.push_back(expect_sweep(2, 1));
        run_sweep(0, 0, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL single_fault.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_double_start();
        res_t obs, exp;
        mode1 = 0;
        sb.push_back(expect_sweep(0, 1));
        run_sweep(0, 10, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL double_start.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        res_t obs, exp;
        bit   done_seen;
        done_seen = 1'b0;
        mode1 = 1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        checks++;
        if (bus1.busy !== 1'b1) $display("FAIL busy_before_reset: got %b, expected 1", bus1.busy);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs(0) !== 64'd0)
            $display("FAIL reset_mid_outputs: got %h, expected 0", all_outs(0));
        else passes++;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus1.done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) $display("FAIL reset_mid_no_done: got %b, expected 0", done_seen);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        mode1 = 0;
        sb.push_back(expect_sweep(0, 1));
        run_sweep(0, 0, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL after_reset.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_settle3();
        res_t obs, exp;
        mode3 = 0;
        sb.push_back(expect_sweep(0, 3));
        run_sweep(1, 0, obs);
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL settle3.%s: got %0d, expected %0d", fname[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_broken();
        test_single_fault();
        test_double_start();
        test_reset_mid();
        test_settle3();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
